// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// The stage builds one 32-bit word from four byte reads on the shared port.
package if_fetch_pkg;

  localparam int unsigned StallBusW    = 6;
  localparam int unsigned InstAddrW    = 32;
  localparam int unsigned InstW        = 32;
  localparam int unsigned ByteW        = 8;
  localparam int unsigned BytesPerInst = 4;

  localparam logic             RstEnable = 1'b1;
  localparam logic             Stop      = 1'b1;
  localparam logic             NoStop    = 1'b0;
  localparam logic [InstW-1:0] ZeroWord  = '0;

  typedef logic [StallBusW-1:0] stall_bus_t;
  typedef logic [InstAddrW-1:0] inst_addr_t;
  typedef logic [InstW-1:0]     inst_t;
  typedef logic [ByteW-1:0]     byte_t;

  typedef enum logic {
    IfFetch = 1'b0,
    IfDone  = 1'b1
  } if_state_e;

  // Little-endian lane insert: byte idx lands in bits [8*idx+7 : 8*idx].
  function automatic inst_t place_byte(input inst_t word, input logic [1:0] idx, input byte_t b);
    inst_t w;
    w = word;
    w[{idx, 3'b000} +: ByteW] = b;
    return w;
  endfunction

endpackage

// File: rtl/if_fetch.sv
// Instruction-fetch stage: issues four byte reads per instruction, assembles the word,
// holds it for the IF/ID hand-off and handles EX branch redirects, including in-flight aborts.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [InstAddrW-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned          STALL_W  = StallBusW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [STALL_W-1:0]   stall,
  input  logic                 branch_flag_i,
  input  logic [InstAddrW-1:0] branch_target_i,
  output logic                 mem_req_o,
  output logic [InstAddrW-1:0] mem_addr_o,
  input  logic                 mem_gnt_i,
  input  logic                 mem_rvalid_i,
  input  logic [ByteW-1:0]     mem_rdata_i,
  output logic [InstAddrW-1:0] if_pc,
  output logic [InstW-1:0]     if_inst,
  output logic                 stallreq_if
);

  if_state_e  state_q, state_d;
  inst_addr_t pc_q, pc_d;
  logic [1:0] byte_cnt_q, byte_cnt_d;
  logic [2:0] issued_q, issued_d;
  logic       outstanding_q, outstanding_d;
  logic       drop_q, drop_d;
  inst_t      asm_q, asm_d;
  inst_addr_t if_pc_q, if_pc_d;
  inst_t      if_inst_q, if_inst_d;

  logic req_ok;
  logic accepted;
  logic take_byte;
  logic last_byte;
  logic handoff;

  // Only the PC/IF bit of the stall bus matters here.
  logic unused_stall;
  assign unused_stall = ^stall;

  // Never issue in a branch cycle; a returning rvalid frees the single outstanding slot.
  assign req_ok    = (state_q == IfFetch) && (issued_q < 3'(BytesPerInst)) &&
                     (!outstanding_q || mem_rvalid_i) && !branch_flag_i;
  assign accepted  = mem_req_o && mem_gnt_i;
  assign take_byte = mem_rvalid_i && !drop_q && !branch_flag_i && (state_q == IfFetch);
  assign last_byte = take_byte && (byte_cnt_q == 2'd3);
  assign handoff   = (state_q == IfDone) && (stall[0] == NoStop);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      state_q       <= IfFetch;
      pc_q          <= RESET_PC;
      byte_cnt_q    <= '0;
      issued_q      <= '0;
      outstanding_q <= 1'b0;
      drop_q        <= 1'b0;
      asm_q         <= ZeroWord;
      if_pc_q       <= ZeroWord;
      if_inst_q     <= ZeroWord;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      byte_cnt_q    <= byte_cnt_d;
      issued_q      <= issued_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      asm_q         <= asm_d;
      if_pc_q       <= if_pc_d;
      if_inst_q     <= if_inst_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    if (branch_flag_i) begin
      state_d = IfFetch;
    end else begin
      unique case (state_q)
        IfFetch: if (last_byte) state_d = IfDone;
        IfDone:  if (handoff)   state_d = IfFetch;
        default: state_d = IfFetch;
      endcase
    end
  end

  // Datapath next values; branch is applied last so it wins over hand-off and capture.
  always_comb begin
    pc_d          = pc_q;
    byte_cnt_d    = byte_cnt_q;
    issued_d      = issued_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    asm_d         = asm_q;
    if_pc_d       = if_pc_q;
    if_inst_d     = if_inst_q;

    if (mem_rvalid_i) begin
      outstanding_d = 1'b0;
      if (drop_q) drop_d = 1'b0;
    end

    if (accepted) begin
      outstanding_d = 1'b1;
      issued_d      = issued_q + 3'd1;
    end

    if (take_byte) begin
      asm_d      = place_byte(asm_q, byte_cnt_q, mem_rdata_i);
      byte_cnt_d = byte_cnt_q + 2'd1;
    end

    if (last_byte) begin
      if_inst_d = {mem_rdata_i, asm_q[23:0]};
      if_pc_d   = pc_q;
    end

    if (handoff) begin
      pc_d       = pc_q + 32'd4;
      byte_cnt_d = '0;
      issued_d   = '0;
      asm_d      = ZeroWord;
    end

    if (branch_flag_i) begin
      pc_d       = {branch_target_i[InstAddrW-1:2], 2'b00};
      byte_cnt_d = '0;
      issued_d   = '0;
      asm_d      = ZeroWord;
      // Read still in flight: its data belongs to the old stream, so discard it on return.
      if (outstanding_q && !mem_rvalid_i) drop_d = 1'b1;
    end
  end

  // Outputs
  always_comb begin
    mem_req_o   = req_ok && (rst != RstEnable);
    mem_addr_o  = pc_q + InstAddrW'(issued_q);
    stallreq_if = (state_q == IfFetch) && (rst != RstEnable);
  end

  assign if_pc   = if_pc_q;
  assign if_inst = if_inst_q;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: a byte memory answering one cycle after grant,
// with hand-computed expected addresses and assembled words.
module tb_if_fetch;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [7:0]  mem_rdata_i;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        stallreq_if;

  int passed;
  int total;

  // Memory-model knobs: hold_rv parks an accepted read instead of answering next cycle.
  logic        hold_rv;
  logic        pend;
  logic [31:0] pend_addr;

  if_fetch #(
    .RESET_PC(32'h0000_0000),
    .STALL_W (6)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .branch_flag_i  (branch_flag_i),
    .branch_target_i(branch_target_i),
    .mem_req_o      (mem_req_o),
    .mem_addr_o     (mem_addr_o),
    .mem_gnt_i      (mem_gnt_i),
    .mem_rvalid_i   (mem_rvalid_i),
    .mem_rdata_i    (mem_rdata_i),
    .if_pc          (if_pc),
    .if_inst        (if_inst),
    .stallreq_if    (stallreq_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Addr 0..3 hold 13 00 00 00; elsewhere byte = a[7:0] ^ {a[11:8], 4'h0}.
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    if (a < 32'd4) return (a == 32'd0) ? 8'h13 : 8'h00;
    return a[7:0] ^ {a[11:8], 4'h0};
  endfunction

  // Advance one clock from a negedge to the next; model returns data 1 cycle after grant.
  task automatic step();
    logic        acc;
    logic [31:0] a;
    #1;
    acc = mem_req_o && mem_gnt_i;
    a   = mem_addr_o;
    @(posedge clk);
    #1;
    if (acc && hold_rv) begin
      pend = 1'b1; pend_addr = a; mem_rvalid_i = 1'b0;
    end else if (acc) begin
      mem_rvalid_i = 1'b1; mem_rdata_i = mem_byte(a);
    end else if (pend && !hold_rv) begin
      mem_rvalid_i = 1'b1; mem_rdata_i = mem_byte(pend_addr); pend = 1'b0;
    end else begin
      mem_rvalid_i = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 6'h01; branch_flag_i = 1'b0; branch_target_i = '0;
    mem_gnt_i = 1'b1; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    hold_rv = 1'b0; pend = 1'b0; pend_addr = '0;
    @(negedge clk); @(negedge clk);
    total++;
    if (if_pc !== 32'h0 || if_inst !== 32'h0)
      $display("FAIL reset_regs: if_pc=%h if_inst=%h, want 0/0", if_pc, if_inst);
    else passed++;
    total++;
    if (mem_req_o !== 1'b0 || stallreq_if !== 1'b0)
      $display("FAIL reset_outs: req=%b stallreq=%b, want 0/0", mem_req_o, stallreq_if);
    else passed++;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_basic_fetch();
    total++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0)
      $display("FAIL basic_req0: req=%b addr=%h, want 1/00000000", mem_req_o, mem_addr_o);
    else passed++;
    for (int i = 1; i < 4; i++) begin
      step();
      total++;
      if (mem_req_o !== 1'b1 || mem_addr_o !== 32'(i))
        $display("FAIL basic_req%0d: req=%b addr=%h, want 1/%h", i, mem_req_o, mem_addr_o, i);
      else passed++;
    end
    step();
    total++;
    if (mem_req_o !== 1'b0 || stallreq_if !== 1'b1)
      $display("FAIL basic_c4: req=%b stallreq=%b, want 0/1", mem_req_o, stallreq_if);
    else passed++;
    step();
    total++;
    if (if_inst !== 32'h0000_0013 || if_pc !== 32'h0 || stallreq_if !== 1'b0)
      $display("FAIL basic_done: inst=%h pc=%h stallreq=%b, want 00000013/00000000/0",
               if_inst, if_pc, stallreq_if);
    else passed++;
  endtask

  task automatic test_stall_hold();
    stall = 6'h01;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (if_pc !== 32'h0 || if_inst !== 32'h13 || mem_req_o !== 1'b0)
        $display("FAIL stall_hold%0d: pc=%h inst=%h req=%b, want 0/13/0",
                 i, if_pc, if_inst, mem_req_o);
      else passed++;
    end
    stall = 6'h00;
    step();
    stall = 6'h01;
    total++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h4 || stallreq_if !== 1'b1)
      $display("FAIL stall_release: req=%b addr=%h stallreq=%b, want 1/00000004/1",
               mem_req_o, mem_addr_o, stallreq_if);
    else passed++;
  endtask

  task automatic test_gnt_wait();
    step();
    total++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h5)
      $display("FAIL gnt_req1: req=%b addr=%h, want 1/00000005", mem_req_o, mem_addr_o);
    else passed++;
    mem_gnt_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h5)
        $display("FAIL gnt_hold%0d: req=%b addr=%h, want 1/00000005", i, mem_req_o, mem_addr_o);
      else passed++;
    end
    mem_gnt_i = 1'b1;
    step();
    step();
    total++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h7)
      $display("FAIL gnt_req3: req=%b addr=%h, want 1/00000007", mem_req_o, mem_addr_o);
    else passed++;
    step();
    step();
    total++;
    if (if_inst !== 32'h0706_0504 || if_pc !== 32'h4)
      $display("FAIL gnt_done: inst=%h pc=%h, want 07060504/00000004", if_inst, if_pc);
    else passed++;
  endtask

  task automatic test_branch_drop();
    stall = 6'h00;
    step();
    stall = 6'h01;
    step();
    step();
    total++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 32'hA)
      $display("FAIL drop_req2: req=%b addr=%h, want 1/0000000a", mem_req_o, mem_addr_o);
    else passed++;
    hold_rv = 1'b1;
    step();
    total++;
    if (mem_req_o !== 1'b0)
      $display("FAIL drop_wait: req=%b, want 0", mem_req_o);
    else passed++;
    branch_flag_i = 1'b1; branch_target_i = 32'h104; hold_rv = 1'b0;
    step();
    branch_flag_i = 1'b0;
    #1;
    total++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h104 || stallreq_if !== 1'b1)
      $display("FAIL drop_redirect: req=%b addr=%h stallreq=%b, want 1/00000104/1",
               mem_req_o, mem_addr_o, stallreq_if);
    else passed++;
    for (int i = 1; i < 4; i++) begin
      step();
      total++;
      if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h104 + 32'(i))
        $display("FAIL drop_req_%0d: req=%b addr=%h, want 1/%h",
                 i, mem_req_o, mem_addr_o, 32'h104 + 32'(i));
      else passed++;
    end
    step();
    step();
    total++;
    if (if_inst !== 32'h1716_1514 || if_pc !== 32'h104)
      $display("FAIL drop_done: inst=%h pc=%h, want 17161514/00000104", if_inst, if_pc);
    else passed++;
  endtask

  task automatic test_branch_handoff();
    stall = 6'h00; branch_flag_i = 1'b1; branch_target_i = 32'h201;
    mem_rvalid_i = 1'b1; mem_rdata_i = 8'hEE;
    step();
    branch_flag_i = 1'b0; stall = 6'h01;
    #1;
    total++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h200 || stallreq_if !== 1'b1)
      $display("FAIL bh_redirect: req=%b addr=%h stallreq=%b, want 1/00000200/1",
               mem_req_o, mem_addr_o, stallreq_if);
    else passed++;
    for (int i = 0; i < 5; i++) step();
    total++;
    if (if_inst !== 32'h2322_2120 || if_pc !== 32'h200)
      $display("FAIL bh_done: inst=%h pc=%h, want 23222120/00000200", if_inst, if_pc);
    else passed++;
  endtask

  task automatic test_wrap_reset();
    branch_flag_i = 1'b1; branch_target_i = 32'hFFFF_FFFE;
    step();
    branch_flag_i = 1'b0;
    #1;
    total++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 32'hFFFF_FFFC)
      $display("FAIL wrap_redirect: req=%b addr=%h, want 1/fffffffc", mem_req_o, mem_addr_o);
    else passed++;
    for (int i = 0; i < 5; i++) step();
    total++;
    if (if_inst !== 32'h0F0E_0D0C || if_pc !== 32'hFFFF_FFFC)
      $display("FAIL wrap_done: inst=%h pc=%h, want 0f0e0d0c/fffffffc", if_inst, if_pc);
    else passed++;
    stall = 6'h00;
    step();
    stall = 6'h01;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (mem_req_o !== 1'b1 || mem_addr_o !== 32'(i))
        $display("FAIL wrap_req%0d: req=%b addr=%h, want 1/%h", i, mem_req_o, mem_addr_o, i);
      else passed++;
      if (i < 2) step();
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (if_pc !== 32'h0 || if_inst !== 32'h0 || mem_req_o !== 1'b0 || stallreq_if !== 1'b0)
      $display("FAIL async_rst: pc=%h inst=%h req=%b stallreq=%b, want 0/0/0/0",
               if_pc, if_inst, mem_req_o, stallreq_if);
    else passed++;
    mem_rvalid_i = 1'b0; pend = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0)
      $display("FAIL rst_restart: req=%b addr=%h, want 1/00000000", mem_req_o, mem_addr_o);
    else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_basic_fetch();
    test_stall_hold();
    test_gnt_wait();
    test_branch_drop();
    test_branch_handoff();
    test_wrap_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
